// File: rtl/ada_bus_arbiter_4.sv
// ada_bus_arbiter_4
// Round-robin arbiter sharing one slave port between four masters.
// Ownership is held until the slave acknowledges. A locked owner that is
// still requesting keeps the bus across acks. A watchdog releases the bus
// when the slave stays silent for TIMEOUT cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-master request, bit i = master i
//   lock[3:0]    per-master lock, only the owner's bit is looked at
//   slave_ack    slave completes the current transfer this cycle
//   grant[3:0]   registered one-hot grant, zero when idle
//   select[1:0]  registered owner index for the datapath mux
//   bus_valid    high while a master owns the bus
//   timeout_err  one-cycle pulse when the watchdog forces a release
module ada_bus_arbiter_4 #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] lock,
    input  logic       slave_ack,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       bus_valid,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic [1:0]       last_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [3:0] req_masked;
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic       win_found;
    logic [1:0] win_idx;

    logic owner_req;
    logic owner_lock;
    logic hold_locked;
    logic timeout_hit;
    logic release_bus;

    // While busy the current owner is left out of the decision; it can
    // only win again through a later arbitration.
    assign req_masked = (state_reg == BUSY) ? (req & ~(4'b0001 << select)) : req;

    // Candidate gi is the (gi+1)-th index after the last winner, so the
    // scan order is last+1, last+2, last+3, last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_hit[gi] = req_masked[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_found = |cand_hit;
        win_idx   = cand_idx[3];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    assign owner_req   = req[select];
    assign owner_lock  = lock[select];
    assign hold_locked = slave_ack && owner_lock && owner_req;
    // Ack beats the watchdog in the same cycle.
    assign timeout_hit = (state_reg == BUSY) && !slave_ack && (cnt_reg == CNT_LIMIT);
    // Unlocked ack, owner abort and watchdog expiry all take the release path.
    assign release_bus = (slave_ack && !hold_locked) || !owner_req || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 2'b11;
            cnt_reg     <= '0;
            grant       <= 4'b0000;
            select      <= 2'b00;
            bus_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_err <= 1'b0;
                    cnt_reg     <= '0;
                    if (win_found) begin
                        state_reg <= BUSY;
                        grant     <= 4'b0001 << win_idx;
                        select    <= win_idx;
                        bus_valid <= 1'b1;
                        last_reg  <= win_idx;
                    end
                end
                BUSY: begin
                    // An abort coinciding with expiry is an ordinary release.
                    timeout_err <= timeout_hit && owner_req;
                    if (release_bus) begin
                        cnt_reg <= '0;
                        if (win_found) begin
                            grant    <= 4'b0001 << win_idx;
                            select   <= win_idx;
                            last_reg <= win_idx;
                        end else begin
                            state_reg <= IDLE;
                            grant     <= 4'b0000;
                            select    <= 2'b00;
                            bus_valid <= 1'b0;
                        end
                    end else if (slave_ack) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    grant       <= 4'b0000;
                    select      <= 2'b00;
                    bus_valid   <= 1'b0;
                    timeout_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ada_bus_arbiter_4.sv
// Testbench for ada_bus_arbiter_4: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// behavioural model of ownership.
module tb_ada_bus_arbiter_4;

    localparam int TIMEOUT = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       slave_ack;
    logic [3:0] grant;
    logic [1:0] select;
    logic       bus_valid;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ada_bus_arbiter_4 #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .lock       (lock),
        .slave_ack  (slave_ack),
        .grant      (grant),
        .select     (select),
        .bus_valid  (bus_valid),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    // owner = -1 when idle; age = bus cycles without ack since ownership began
    int m_owner = -1;
    int m_last  = 3;
    int m_age   = 0;
    bit m_err   = 1'b0;

    function automatic int pick(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 3;
            m_age   = 0;
            m_err   = 1'b0;
        end else begin
            bit nerr;
            nerr = 1'b0;
            if (m_owner < 0) begin
                int w;
                w = pick(req, m_last, -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_age   = 0;
                end
            end else begin
                int o;
                bit oreq;
                bit expired;
                o = m_owner;
                oreq = req[o];
                expired = (m_age + 1 >= TIMEOUT);
                if (slave_ack && lock[o] && oreq) begin
                    m_age = 0;
                end else if (slave_ack || !oreq || expired) begin
                    int w;
                    nerr = !slave_ack && oreq && expired;
                    w = pick(req, m_last, o);
                    m_owner = w;
                    if (w >= 0) m_last = w;
                    m_age = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end
            m_err = nerr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [3:0] prev_grant = 4'b0000;
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] eg;
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            chk("model_grant", {28'd0, grant}, {28'd0, eg});
            chk("model_bus_valid", {31'd0, bus_valid}, {31'd0, (m_owner >= 0)});
            chk("model_timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
            if (m_owner >= 0) chk("model_select", {30'd0, select}, m_owner);
            else chk("model_select_idle", {30'd0, select}, 32'd0);
            if (grant !== prev_grant)
                $display("cycle %0d grant=%b select=%0d valid=%0b terr=%0b",
                         cyc, grant, select, bus_valid, timeout_err);
            prev_grant = grant;
        end
        n_checks++;
        assert ($countones(grant) <= 1)
        else begin
            n_errors++;
            $display("FAIL grant_onehot: got %b expected at most one bit", grant);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        lock = 4'b0000;
        slave_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        int exp_rr [4] = '{1, 2, 3, 0};
        rst_n = 1'b0;
        req = 4'b0000;
        lock = 4'b0000;
        slave_ack = 1'b0;
        #1;
        // reset state while rst_n is low
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_select", {30'd0, select}, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_grant", {28'd0, grant}, 32'd0);

        // single request
        req = 4'b0100;
        step();
        chk("single_grant", {28'd0, grant}, 32'h4);
        chk("single_select", {30'd0, select}, 32'd2);
        chk("single_valid", {31'd0, bus_valid}, 32'd1);
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        req = 4'b0000;
        chk("single_release_grant", {28'd0, grant}, 32'd0);
        chk("single_release_valid", {31'd0, bus_valid}, 32'd0);
        $display("single request transaction done");

        // round robin, ack every second cycle
        do_reset();
        req = 4'b1111;
        step();
        chk("rr_first_owner", {30'd0, select}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("rr_hold_valid", {31'd0, bus_valid}, 32'd1);
            slave_ack = 1'b1;
            step();
            slave_ack = 1'b0;
            chk("rr_owner", {30'd0, select}, exp_rr[n]);
            chk("rr_no_idle", {31'd0, bus_valid}, 32'd1);
        end
        $display("round robin transaction done");

        // lock
        do_reset();
        req = 4'b0011;
        lock = 4'b0001;
        step();
        for (int n = 0; n < 3; n++) begin
            slave_ack = 1'b1;
            step();
            chk("lock_keep_owner", {30'd0, select}, 32'd0);
        end
        lock = 4'b0000;
        step();
        chk("lock_drop_owner", {30'd0, select}, 32'd1);
        slave_ack = 1'b0;
        req = 4'b0000;
        step();
        $display("lock transaction done");

        // watchdog timeout: grant visible in cycle 1, pulse in cycle 9
        do_reset();
        req = 4'b0010;
        step();
        chk("to_grant", {28'd0, grant}, 32'h2);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("to_no_pulse_yet", {31'd0, timeout_err}, 32'd0);
        end
        step();
        chk("to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("to_released", {28'd0, grant}, 32'd0);
        req = 4'b0000;
        step();
        chk("to_pulse_one_cycle", {31'd0, timeout_err}, 32'd0);
        $display("timeout transaction done");

        // same, with ack in cycle 8
        do_reset();
        req = 4'b0010;
        step();
        for (int c = 2; c <= 7; c++) step();
        slave_ack = 1'b1;
        step();
        slave_ack = 1'b0;
        req = 4'b0000;
        chk("ack8_no_pulse", {31'd0, timeout_err}, 32'd0);
        chk("ack8_released", {28'd0, grant}, 32'd0);
        step();
        chk("ack8_still_no_pulse", {31'd0, timeout_err}, 32'd0);
        $display("ack-before-timeout transaction done");

        // abort by owner 3 while master 1 waits, then reset mid-transfer
        do_reset();
        req = 4'b1000;
        step();
        chk("abort_owner3", {30'd0, select}, 32'd3);
        req = 4'b1010;
        step();
        chk("abort_still3", {30'd0, select}, 32'd3);
        req = 4'b0010;
        step();
        chk("abort_owner1", {30'd0, select}, 32'd1);
        chk("abort_no_err", {31'd0, timeout_err}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {28'd0, grant}, 32'd0);
        chk("async_rst_valid", {31'd0, bus_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        req = 4'b0000;
        step();
        $display("abort/reset transaction done");

        // randomized run against the model
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            bit quiet;
            quiet = ((c / 64) % 2) == 1;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            req = r;
            lock = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            slave_ack = quiet ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
            if ($urandom_range(999) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("rand_async_rst", {28'd0, grant}, 32'd0);
                step();
                rst_n = 1'b1;
            end
            step();
        end
        req = 4'b0000;
        lock = 4'b0000;
        slave_ack = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
